// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
// 8N1 UART receiver for the SoC's uart_tx line. Received bytes go into a small
// first-word-fall-through FIFO and leave as a valid/ready byte stream.
//
// Ports
//   wb_clk      system clock, rising edge
//   wb_rst      synchronous active-high reset
//   uart_rx     asynchronous serial input, idle high
//   rx_data     byte at FIFO head (meaningful while rx_valid)
//   rx_valid    FIFO not empty
//   rx_ready    consumer takes rx_data this cycle
//   rx_busy     receiver is inside a frame (FSM not idle)
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good byte dropped, FIFO full
//   fifo_level  bytes held, 0..FIFO_DEPTH
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 208,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             uart_rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_e;

  // synchronizer
  logic meta_q, meta_d, rx_s_q, rx_s_d;

  // receive FSM
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          ferr_q, ferr_d;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovr_q, ovr_d;
  logic             full, do_pop, do_push;

  // Synchronizer and FSM next state. The cycle counter free-runs and is
  // cleared on every state change or sample point.
  always_comb begin
    meta_d  = uart_rx;
    rx_s_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;  // too short to be a start bit
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) raises only one error, then waits here.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO: a pop frees the slot a same-cycle push needs, so a full FIFO only
  // drops the byte when nobody is reading.
  always_comb begin
    fifo_level = wptr_q - rptr_q;
    full       = (fifo_level == DEPTH_L);
    rx_valid   = (fifo_level != '0);
    do_pop     = rx_valid & rx_ready;
    do_push    = push_q & (~full | do_pop);
    ovr_d      = push_q & full & ~do_pop;
    wptr_d     = wptr_q + (FIFO_AW + 1)'(do_push);
    rptr_d     = rptr_q + (FIFO_AW + 1)'(do_pop);
    mem_d      = mem_q;
    if (do_push) mem_d[wptr_q[FIFO_AW-1:0]] = shift_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      meta_q  <= meta_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
    end
  end

  assign rx_data = mem_q[rptr_q[FIFO_AW-1:0]];
  assign rx_busy = (state_q != S_IDLE);
  // Registered pulses may still be high in the first reset cycle; mask them.
  assign frame_err = ferr_q & ~wb_rst;
  assign overrun   = ovr_q & ~wb_rst;

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;
  localparam int CPB   = 208;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  // Push cycle offset from the start-bit edge: 2 sync flops + idle detect,
  // half a bit in START, eight data bits and the stop bit.
  localparam int PUSH_OFS = 3 + CPB / 2 + 9 * CPB;

  logic wb_clk = 1'b0, wb_rst = 1'b1, uart_rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, frame_err, overrun;
  logic [AW:0] fifo_level;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun), .fifo_level(fifo_level));

  always #5 wb_clk = ~wb_clk;

  int errors = 0, checks = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, flag_rst_cnt = 0;
  logic [7:0] got_q[$];
  int pop_cyc[$];

  // Observer on the falling edge: records accepted bytes and counts pulses.
  always @(negedge wb_clk) begin
    cyc++;
    if (!wb_rst && rx_valid && rx_ready) begin
      got_q.push_back(rx_data);
      pop_cyc.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_busy) busy_cnt++;
    if (wb_rst && (frame_err || overrun)) flag_rst_cnt++;
  end

  task automatic clk(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    uart_rx = 1'b0;
    clk(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      clk(CPB);
    end
    if (stop_low_bits > 0) begin
      uart_rx = 1'b0;
      clk(stop_low_bits * CPB);
    end
    uart_rx = 1'b1;
    clk(CPB);
  endtask

  task automatic test_reset;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %0b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %0b want 0", overrun); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h want 0", rx_data); end
  endtask

  task automatic test_basic;
    logic [7:0] exp_b[2];
    int g0 = got_q.size(), b0 = busy_cnt, f0 = fe_cnt, o0 = ov_cnt;
    exp_b[0] = 8'h55; exp_b[1] = 8'hA3;
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) send_frame(exp_b[i], 0);
    clk(4);
    checks++;
    if (got_q.size() - g0 !== 2) begin
      errors++; $display("FAIL basic_count: got %0d want 2", got_q.size() - g0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[g0+i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %0h want %0h", i, got_q[g0+i], exp_b[i]); end
      end
    end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL basic_ferr: got %0d want 0", fe_cnt - f0); end
    checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL basic_ovr: got %0d want 0", ov_cnt - o0); end
    checks++;
    if (busy_cnt - b0 !== 2 * (CPB / 2 + 9 * CPB)) begin
      errors++; $display("FAIL basic_busy: got %0d want %0d", busy_cnt - b0, 2 * (CPB / 2 + 9 * CPB));
    end
  endtask

  task automatic test_glitch;
    int g0 = got_q.size(), b0 = busy_cnt, f0 = fe_cnt, o0 = ov_cnt;
    uart_rx = 1'b0;
    clk(40);
    uart_rx = 1'b1;
    clk(200);
    checks++; if (busy_cnt - b0 !== CPB / 2) begin errors++; $display("FAIL glitch_busy: got %0d want %0d", busy_cnt - b0, CPB / 2); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %0b want 0", rx_busy); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL glitch_level: got %0d want 0", fifo_level); end
    checks++; if (got_q.size() - g0 !== 0) begin errors++; $display("FAIL glitch_push: got %0d want 0", got_q.size() - g0); end
    checks++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_frame_err;
    int f0 = fe_cnt, g0;
    rx_ready = 1'b0;
    send_frame(8'h41, 3);
    clk(CPB);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL ferr_level: got %0d want 0", fifo_level); end
    send_frame(8'h42, 0);
    clk(4);
    checks++; if (fifo_level !== 1) begin errors++; $display("FAIL ferr_next_level: got %0d want 1", fifo_level); end
    checks++; if (rx_data !== 8'h42) begin errors++; $display("FAIL ferr_next_data: got %0h want 42", rx_data); end
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_repeat: got %0d want 1", fe_cnt - f0); end
    g0 = got_q.size();
    rx_ready = 1'b1;
    clk(1);
    rx_ready = 1'b0;
    clk(2);
    checks++; if (got_q.size() - g0 !== 1 || fifo_level !== '0) begin errors++; $display("FAIL ferr_drain: got pops=%0d level=%0d want 1/0", got_q.size() - g0, fifo_level); end
  endtask

  // Compares the drained bytes with the model queue, and checks back-to-back pops.
  task automatic test_overrun;
    logic [7:0] mdl[$];
    int exp_ov = 0, o0 = ov_cnt, g0;
    rx_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      send_frame(8'(b), 0);
      if (mdl.size() < DEPTH) mdl.push_back(8'(b));
      else exp_ov++;
      clk($urandom_range(0, 40));
    end
    clk(4);
    checks++; if (fifo_level !== (AW+1)'(mdl.size())) begin errors++; $display("FAIL ovr_level: got %0d want %0d", fifo_level, mdl.size()); end
    checks++; if (ov_cnt - o0 !== exp_ov) begin errors++; $display("FAIL ovr_count: got %0d want %0d", ov_cnt - o0, exp_ov); end
    checks++; if (rx_data !== mdl[0]) begin errors++; $display("FAIL ovr_head: got %0h want %0h", rx_data, mdl[0]); end
    g0 = got_q.size();
    rx_ready = 1'b1;
    clk(DEPTH + 2);
    rx_ready = 1'b0;
    checks++;
    if (got_q.size() - g0 !== mdl.size()) begin
      errors++; $display("FAIL ovr_drain_count: got %0d want %0d", got_q.size() - g0, mdl.size());
    end else begin
      for (int i = 0; i < mdl.size(); i++) begin
        checks++;
        if (got_q[g0+i] !== mdl[i]) begin errors++; $display("FAIL ovr_drain%0d: got %0h want %0h", i, got_q[g0+i], mdl[i]); end
      end
      checks++;
      if (pop_cyc[g0+mdl.size()-1] - pop_cyc[g0] !== mdl.size() - 1) begin
        errors++; $display("FAIL ovr_drain_rate: got span %0d want %0d", pop_cyc[g0+mdl.size()-1] - pop_cyc[g0], mdl.size() - 1);
      end
    end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL ovr_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] mdl[$];
    logic [7:0] r, first;
    int o0, g0;
    rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r = 8'($urandom);
      send_frame(r, 0);
      mdl.push_back(r);
    end
    clk(4);
    checks++; if (fifo_level !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL fpp_full: got %0d want %0d", fifo_level, DEPTH); end
    o0 = ov_cnt;
    g0 = got_q.size();
    fork
      send_frame(8'h99, 0);
      begin
        clk(PUSH_OFS);
        rx_ready = 1'b1;
        clk(1);
        rx_ready = 1'b0;
      end
    join
    first = mdl.pop_front();
    mdl.push_back(8'h99);
    clk(4);
    checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL fpp_ovr: got %0d want 0", ov_cnt - o0); end
    checks++; if (fifo_level !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL fpp_level: got %0d want %0d", fifo_level, DEPTH); end
    checks++;
    if (got_q.size() - g0 !== 1 || got_q[g0] !== first) begin
      errors++; $display("FAIL fpp_pop: got n=%0d byte=%0h want 1/%0h", got_q.size() - g0, got_q[g0], first);
    end
    g0 = got_q.size();
    rx_ready = 1'b1;
    clk(DEPTH + 2);
    rx_ready = 1'b0;
    checks++;
    if (got_q.size() - g0 !== DEPTH) begin
      errors++; $display("FAIL fpp_drain_count: got %0d want %0d", got_q.size() - g0, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (got_q[g0+i] !== mdl[i]) begin errors++; $display("FAIL fpp_drain%0d: got %0h want %0h", i, got_q[g0+i], mdl[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] partial = 8'h5A;
    int f0, r0 = flag_rst_cnt, g0;
    rx_ready = 1'b0;
    send_frame(8'h77, 0);
    clk(4);
    checks++; if (fifo_level !== 1) begin errors++; $display("FAIL mrst_pre_level: got %0d want 1", fifo_level); end
    uart_rx = 1'b0;
    clk(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = partial[i];
      clk(CPB);
    end
    uart_rx = partial[4];
    clk(100);
    wb_rst = 1'b1;
    uart_rx = 1'b1;
    clk(2);
    wb_rst = 1'b0;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %0b want 0", rx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %0b want 0", rx_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mrst_level: got %0d want 0", fifo_level); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mrst_data: got %0h want 0", rx_data); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mrst_flags: got %0b%0b want 00", frame_err, overrun); end
    checks++; if (flag_rst_cnt - r0 !== 0) begin errors++; $display("FAIL mrst_flag_in_rst: got %0d want 0", flag_rst_cnt - r0); end
    clk(CPB);
    f0 = fe_cnt;
    g0 = got_q.size();
    rx_ready = 1'b1;
    send_frame(8'hC3, 0);
    clk(4);
    checks++;
    if (got_q.size() - g0 !== 1 || got_q[g0] !== 8'hC3) begin
      errors++; $display("FAIL mrst_next: got n=%0d byte=%0h want 1/c3", got_q.size() - g0, got_q[g0]);
    end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL mrst_next_ferr: got %0d want 0", fe_cnt - f0); end
  endtask

  initial begin
    clk(3);
    wb_rst = 1'b0;
    clk(2);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Synthesizable 8N1 UART receiver, the listening end of the SoC's uart_tx line.
- Recovers bytes sent by the boot monitor and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Output side is a valid/ready byte stream, for bench console capture or a host-side bridge.
- Runs in the wb_clk domain next to the SoC.

Parameters:
- CLKS_PER_BIT, 208: wb_clk cycles per UART bit (24 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 8: byte FIFO entries; power of two, >= 2.
- FIFO_AW, 3: log2(FIFO_DEPTH); width of the pointers.

Ports:
- wb_clk  in  1  system clock; all logic on its rising edge.
- wb_rst  in  1  synchronous active-high reset.
- uart_rx  in  1  asynchronous serial line, idle high.
- rx_data  out  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- rx_busy  out  1  receive FSM not in IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte dropped because FIFO full.
- fifo_level  out  FIFO_AW+1  number of bytes held, 0..FIFO_DEPTH.

Behaviour:
- Reset values:
  - Synchronizer flops = 1; FSM = IDLE; bit counter and cycle counter = 0.
  - Read and write pointers = 0; rx_valid = 0; rx_busy = 0; frame_err = 0; overrun = 0; fifo_level = 0.
  - rx_data = 0x00 after reset, since it shows memory at pointer 0 and that memory is cleared.
- Reset mid-frame: the partial byte is discarded and FIFO contents are lost. Reception restarts at the next falling edge seen after wb_rst deasserts.
- Input sync: two-flop synchronizer on uart_rx; the FSM uses only the synchronized bit (rx_s).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. The cycle counter cnt is zeroed on every state entry.
  - IDLE: rx_s=0 -> START.
  - START: at cnt = CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s=0: go to DATA with bit index 0.
    - rx_s=1: glitch; back to IDLE with no flag.
  - DATA: at cnt = CLKS_PER_BIT-1, sample rx_s into shift register LSB-first and clear cnt.
    - After bit 7 -> STOP.
  - STOP: at cnt = CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: push byte, -> IDLE.
    - rx_s=0: pulse frame_err, discard byte, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then -> IDLE. Covers break and long low lines with no repeated errors.
- rx_busy = (state != IDLE).
- FIFO:
  - Push occurs on the cycle after the stop sample. rx_valid rises one cycle after the push.
  - Pop when rx_valid & rx_ready. Head advances next cycle; rx_data shows the next entry with no extra latency.
  - Full, push, no pop: byte dropped, overrun pulses one cycle, FIFO unchanged.
  - Full, push and pop in the same cycle: both happen; level stays FIFO_DEPTH; no overrun.
  - Empty: rx_ready ignored; pointers unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by fifo_level, i.e. write count minus read count with FIFO_AW+1 bits.
- frame_err and overrun are never asserted in the same cycle as wb_rst.

Test Plan:
- Send 0x55 then 0xA3, 208 clocks/bit, rx_ready=1 -> rx_valid pulses twice with rx_data 0x55 then 0xA3; frame_err=0; overrun=0; rx_busy high during each frame.
- 40-clock low glitch on idle line -> rx_busy high under 110 cycles then low; no push; fifo_level stays 0; no flags.
- Frame 0x41 with stop bit held 0 for 3 bit times -> exactly one frame_err pulse; fifo_level 0. A following good 0x42 is received as 0x42.
- rx_ready=0, send 0x01..0x09 -> fifo_level reaches 8; one overrun pulse on 0x09. Raising rx_ready then drains 0x01..0x08 in order, one per cycle.
- FIFO full, rx_ready pulsed in the exact push cycle of a 9th byte 0x99 -> no overrun; level stays 8. The drain order ends with 0x99.
- Assert wb_rst for 2 cycles during bit 4 of a frame -> all outputs return to reset values. The next full frame 0xC3 is received correctly.
